// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding, reset PC default and redirect-source encoding for the fetch sequencer
package pc_sequencer_pkg;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} seq_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_BRANCH, SRC_JUMP, SRC_EXC} redirect_src_t;
endpackage

// File: rtl/pc_sequencer_redirect_arbiter.sv
// pc_sequencer_redirect_arbiter: fixed-priority redirect select (exception > jump > taken branch); BRANCH_DELAY_SLOT_EN limits flush to exceptions
module pc_sequencer_redirect_arbiter
  import pc_sequencer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_vector,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              branch_valid,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] rd_target,
  output logic              rd_flush
);
  redirect_src_t src;
  // highest-priority active redirect source; a not-taken branch is no redirect
  always_comb src = exc_valid ? SRC_EXC : jump_valid ? SRC_JUMP : (branch_valid && branch_taken) ? SRC_BRANCH : SRC_NONE;
  // target of the chosen source and whether it squashes the in-flight instruction
  always_comb begin
    rd_valid  = src != SRC_NONE;
    rd_target = src == SRC_EXC ? exc_vector : src == SRC_JUMP ? jump_target : branch_target;
`ifdef BRANCH_DELAY_SLOT_EN
    rd_flush  = src == SRC_EXC;
`else
    rd_flush  = rd_valid;
`endif
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC owner and imem request sequencer with one-entry hold; optional BRANCH_DELAY_SLOT_EN keeps the slot instruction
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic              stall,
  output logic              inst_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              branch_valid,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_vector,
  output logic              flush
);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] RST_PC4 = RST_PC + ADDR_W'(4);
  seq_state_t        state;
  logic              rd_valid, rd_flush, kill, defer, pend;
  logic [ADDR_W-1:0] rd_target, tgt, pend_t, addr_inc, pc_inc;
  pc_sequencer_redirect_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .exc_valid(exc_valid), .exc_vector(exc_vector),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .branch_valid(branch_valid), .branch_taken(branch_taken), .branch_target(branch_target),
    .rd_valid(rd_valid), .rd_target(rd_target), .rd_flush(rd_flush)
  );
  // kill squashes the in-flight/held instruction; defer redirects only after the slot instruction
  always_comb begin
    kill     = rd_flush;
    defer    = rd_valid && !rd_flush;
    flush    = rd_flush;
    addr_inc = imem_addr + ADDR_W'(4);
    pc_inc   = pc_out + ADDR_W'(4);
  end
  // fetch FSM: request issue, delivery, hold under stall, draining of squashed responses
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= RST_PC;
      inst_valid <= 1'b0;
      pc_out     <= RST_PC;
      pc_plus4   <= RST_PC4;
      tgt        <= RST_PC;
      pend       <= 1'b0;
      pend_t     <= RST_PC;
    end else begin
      case (state)
        IDLE: begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= rd_valid ? rd_target : RST_PC;
        end
        REQ:
          if (kill) begin
            state      <= imem_ack ? REQ : DRAIN;
            imem_addr  <= imem_ack ? rd_target : imem_addr;
            tgt        <= rd_target;
            inst_valid <= 1'b0;
            pend       <= 1'b0;
          end else if (imem_ack) begin
            inst_valid <= 1'b1;
            pc_out     <= imem_addr;
            pc_plus4   <= addr_inc;
            if (stall) begin
              state    <= HOLD;
              imem_req <= 1'b0;
              pend     <= pend || defer;
              pend_t   <= defer ? rd_target : pend_t;
            end else begin
              imem_addr <= defer ? rd_target : pend ? pend_t : addr_inc;
              pend      <= 1'b0;
            end
          end else begin
            inst_valid <= 1'b0;
            pend       <= pend || defer;
            pend_t     <= defer ? rd_target : pend_t;
          end
        HOLD:
          if (kill || !stall) begin
            state      <= REQ;
            imem_req   <= 1'b1;
            inst_valid <= 1'b0;
            pend       <= 1'b0;
            imem_addr  <= rd_valid ? rd_target : pend ? pend_t : pc_inc;
          end else begin
            pend   <= pend || defer;
            pend_t <= defer ? rd_target : pend_t;
          end
        DRAIN: begin
          tgt <= rd_valid ? rd_target : tgt;
          if (imem_ack) begin
            state     <= REQ;
            imem_addr <= rd_valid ? rd_target : tgt;
          end
        end
      endcase
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences instruction-memory requests for the MIPS32 core. Consumes the resolved branch decision, jump and exception redirects from later stages, picks the next PC by fixed priority, squashes wrong-path instructions and handles downstream stalls with a one-entry instruction hold.

## Interface
Parameters:
- RESET_PC, 32'h0040_0000, first fetch address after reset
- ADDR_W, 32, address/PC width

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request; held until imem_ack
- imem_addr  out  ADDR_W  fetch address; stable while imem_req=1
- imem_ack  in  1  response for the outstanding request (data sampled by the IF/ID register)
- stall  in  1  decode cannot accept an instruction this cycle
- inst_valid  out  1  delivered instruction is valid
- pc_out  out  ADDR_W  PC of delivered instruction
- pc_plus4  out  ADDR_W  pc_out + 4
- branch_valid  in  1  EX-stage branch resolved this cycle
- branch_taken  in  1  branch-resolver outcome
- branch_target  in  ADDR_W  branch destination
- jump_valid  in  1  jump redirect
- jump_target  in  ADDR_W  jump destination
- exc_valid  in  1  exception redirect
- exc_vector  in  ADDR_W  exception handler address
- flush  out  1  squash younger in-pipe instructions (combinational)

## Operation
- Redirect priority: exc_valid > jump_valid > (branch_valid & branch_taken). Not-taken branch: no effect. Selected target becomes next fetch address.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: entered on reset; no request. Next cycle -> REQ with imem_addr=RESET_PC.
- REQ: imem_req=1. On imem_ack without redirect: inst_valid=1, pc_out=imem_addr; if stall=0 issue next request at imem_addr+4 (stay REQ), else -> HOLD, imem_req=0.
- HOLD: inst_valid, pc_out held. When stall=0: instruction consumed, -> REQ at pc_out+4.
- Redirect in REQ with request outstanding and no ack same cycle -> DRAIN; target latched; imem_req stays 1 with unchanged address (no abort). On ack in DRAIN: response discarded (inst_valid=0), -> REQ at latched target.
- Redirect coinciding with imem_ack, or in HOLD/IDLE: response/held instruction dropped, inst_valid=0 next cycle, -> REQ at target.
- Redirect in DRAIN: latched target overwritten (newest wins, priority applies within cycle).
- flush = any selected redirect (subject to Configuration).
- PC arithmetic modulo 2^ADDR_W; +4 wraps silently.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, inst_valid=0, pc_out=RESET_PC, pc_plus4=RESET_PC+4, flush=0 (inputs low), state IDLE.
- All outputs registered except flush (same cycle as redirect input).
- Back-to-back: with single-cycle ack and stall=0, one instruction per cycle; address sequence N, N+4, ... with no bubble.
- Redirect-to-target-request latency: 1 cycle (REQ/HOLD/IDLE); ack + 1 cycle in DRAIN.
- stall only gates delivery/new requests; never withdraws an outstanding imem_req.
- rst_n assertion mid-request: immediate return to IDLE; a late imem_ack after reset is ignored in IDLE.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: branch/jump redirects do not assert flush and the instruction at redirect-PC+4 (in flight or held) is delivered normally; target fetched after it. Exceptions still flush and discard.
- Undefined: every redirect flushes and discards as described in Operation.

## Structure
- Shared package: state encoding enum (IDLE, REQ, HOLD, DRAIN), RESET_PC default, redirect-source encoding.
- Sub-module: redirect_arbiter (combinational priority select of target + valid + flush qualifier); FSM and PC registers stay in pc_sequencer.

## Test plan
- Reset release, ack every cycle, stall=0 -> imem_addr 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; inst_valid from cycle 2.
- stall=1 for 3 cycles after ack of 0x00400004 -> inst_valid/pc_out held at 0x00400004, imem_req=0; after release next request 0x00400008.
- Taken branch to 0x00400100 while 0x00400010 outstanding, ack 2 cycles later -> flush=1 same cycle, 0x00400010 response discarded, next imem_addr 0x00400100.
- Same-cycle exc_valid (0x80000180), jump_valid and taken branch -> imem_addr 0x80000180; with BRANCH_DELAY_SLOT_EN branch alone to 0x00400100 -> flush=0, slot instruction delivered, then 0x00400100.
- branch_valid=1, branch_taken=0 -> no flush, sequential fetch continues.
- rst_n low while request outstanding -> imem_req=0 immediately; late imem_ack ignored; restart at RESET_PC.
